// File: rtl/wspr_symbol_scheduler_pkg.sv
// Shared types and constants for the WSPR symbol scheduler.
package wspr_pkg;

    localparam int NUM_SYMBOLS           = 162;
    localparam int SYMBOL_CYCLES_DEFAULT = 6826667;   // 8192/12000 s at 10 MHz

    typedef logic [1:0] wspr_sym_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        FETCH = 2'd2,
        HOLD  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/wspr_symbol_scheduler_if.sv
// Symbol buffer read bus plus the symbol stream handed to the tone generator.
interface wspr_symbol_scheduler_if #(parameter int ADDR_W = 8);
    import wspr_pkg::*;

    logic [ADDR_W-1:0] sym_addr;
    wspr_sym_t         sym_data;
    wspr_sym_t         current;
    logic              symbol_strobe;
    logic              tx_active;
    logic              done;

    modport master (
        output sym_addr, current, symbol_strobe, tx_active, done,
        input  sym_data
    );

    modport slave (
        input  sym_addr, current, symbol_strobe, tx_active, done,
        output sym_data
    );
endinterface

// File: rtl/wspr_start_sync.sv
// Two-flop synchroniser for the asynchronous start pad, followed by a
// registered rising-edge detector so a held level fires only once.
module wspr_start_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic start_pulse
);
    logic sync1_reg, sync2_reg, sync3_reg, pulse_reg;

    // Synchronise, delay once more, and register the 0->1 transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            sync3_reg <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            sync1_reg <= start;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
            pulse_reg <= sync2_reg & ~sync3_reg;
        end
    end

    assign start_pulse = pulse_reg;
endmodule

// File: rtl/wspr_symbol_scheduler.sv
// Sequences one WSPR transmission: fetches 162 channel symbols from the
// encoder buffer and holds each on `current` for SYMBOL_CYCLES clocks.
// Optional feature macro WSPR_SLOT_SYNC_EN: after a start request, wait in
// ARM for slot_tick before fetching the first symbol.
module wspr_symbol_scheduler
    import wspr_pkg::*;
#(
    parameter int SYMBOL_CYCLES = SYMBOL_CYCLES_DEFAULT,
    parameter int ADDR_W        = 8,
    parameter int CNT_W         = 23
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic encoding_valid,
    input  logic slot_tick,
    wspr_symbol_scheduler_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_ARM   = 2'(ARM);
    localparam logic [1:0] S_FETCH = 2'(FETCH);
    localparam logic [1:0] S_HOLD  = 2'(HOLD);

    localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(SYMBOL_CYCLES - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST   = ADDR_W'(NUM_SYMBOLS - 1);
    localparam logic [ADDR_W:0]   IDX_LAST_W = (ADDR_W+1)'(NUM_SYMBOLS - 1);

`ifdef WSPR_SLOT_SYNC_EN
    localparam logic [1:0] S_AFTER_START = S_ARM;
    logic slot_go;
    assign slot_go = slot_tick;
`else
    // slot_tick stays on the port list so both builds share one interface
    localparam logic [1:0] S_AFTER_START = S_FETCH;
    logic slot_go;
    logic slot_tick_unused;
    assign slot_go          = 1'b0;
    assign slot_tick_unused = slot_tick;
`endif

    logic              start_pulse;
    logic [1:0]        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [ADDR_W-1:0] addr_reg;
    wspr_sym_t         current_reg;
    logic              strobe_reg;
    logic              active_reg;
    logic              done_reg;

    logic              stop_req;
    logic              last_sym;
    logic [ADDR_W:0]   ahead_wide;
    logic [ADDR_W-1:0] ahead_addr;

    wspr_start_sync u_start_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_pulse (start_pulse)
    );

    // An abort or a vanished message cancels anything past IDLE
    assign stop_req = abort | ~encoding_valid;
    assign last_sym = (idx_reg == IDX_LAST);

    // Prefetch address for the symbol after next, clamped to the final symbol
    assign ahead_wide = {1'b0, idx_reg} + (ADDR_W+1)'(2);
    assign ahead_addr = (ahead_wide > IDX_LAST_W) ? IDX_LAST : ahead_wide[ADDR_W-1:0];

    // Scheduler FSM with symbol timer, symbol index and buffer address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            addr_reg    <= '0;
            current_reg <= '0;
            strobe_reg  <= 1'b0;
            active_reg  <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            strobe_reg <= 1'b0;
            done_reg   <= 1'b0;
            if (state_reg != S_IDLE && stop_req) begin
                state_reg   <= S_IDLE;
                cnt_reg     <= '0;
                idx_reg     <= '0;
                addr_reg    <= '0;
                current_reg <= '0;
                active_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        cnt_reg <= '0;
                        idx_reg <= '0;
                        if (start_pulse && encoding_valid) begin
                            state_reg <= S_AFTER_START;
                            addr_reg  <= '0;
                        end
                    end
                    S_ARM: begin
                        if (slot_go) begin
                            state_reg <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        state_reg   <= S_HOLD;
                        current_reg <= bus.sym_data;
                        strobe_reg  <= 1'b1;
                        active_reg  <= 1'b1;
                        idx_reg     <= '0;
                        cnt_reg     <= CNT_LOAD;
                        addr_reg    <= ADDR_W'(1);
                    end
                    S_HOLD: begin
                        if (cnt_reg != '0) begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end else if (last_sym) begin
                            state_reg   <= S_IDLE;
                            current_reg <= '0;
                            active_reg  <= 1'b0;
                            done_reg    <= 1'b1;
                            addr_reg    <= '0;
                            idx_reg     <= '0;
                            cnt_reg     <= '0;
                        end else begin
                            current_reg <= bus.sym_data;
                            strobe_reg  <= 1'b1;
                            idx_reg     <= idx_reg + 1'b1;
                            cnt_reg     <= CNT_LOAD;
                            addr_reg    <= ahead_addr;
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.sym_addr      = addr_reg;
    assign bus.current       = current_reg;
    assign bus.symbol_strobe = strobe_reg;
    assign bus.tx_active     = active_reg;
    assign bus.done          = done_reg;
endmodule

// File: tb/tb_wspr_symbol_scheduler.sv
// Directed bench for wspr_symbol_scheduler with SYMBOL_CYCLES=4 and a
// registered-read symbol buffer preloaded with sym[k] = k % 4.
module tb_wspr_symbol_scheduler;
    import wspr_pkg::*;

    logic clk = 1'b0;
    logic rst_n, start, abort, encoding_valid, slot_tick;
    logic [1:0] mem [0:255];
    int checks = 0;
    int failures = 0;

    wspr_symbol_scheduler_if #(.ADDR_W(8)) bus ();

    wspr_symbol_scheduler #(.SYMBOL_CYCLES(4), .ADDR_W(8), .CNT_W(23)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .encoding_valid (encoding_valid),
        .slot_tick      (slot_tick),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // Symbol buffer: data valid one clock after the address
    always @(posedge clk) bus.sym_data <= mem[bus.sym_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance until the next strobe, bounded; returns clocks taken
    task automatic wait_strobe(input string tag, input int budget, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!bus.symbol_strobe && waited < budget);
        chk(tag, bus.symbol_strobe, 1);
    endtask

    initial begin
        int strobes, active_cyc, dones, cyc, last_cyc, waited, first_cyc, seen;

        for (int k = 0; k < 256; k++) mem[k] = 2'(k % 4);
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; encoding_valid = 1'b0; slot_tick = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_current", bus.current, 0);
        chk("rst_addr", bus.sym_addr, 0);
        chk("rst_active", bus.tx_active, 0);
        chk("rst_strobe", bus.symbol_strobe, 0);
        chk("rst_done", bus.done, 0);
        rst_n = 1'b1;
        tick();
        $display("step reset: done");

        // Full transmission
        encoding_valid = 1'b1;
        start = 1'b1;
        repeat (4) tick();
        chk("t2_no_early_strobe", bus.symbol_strobe, 0);
        tick();
        chk("t2_first_strobe", bus.symbol_strobe, 1);
        chk("t2_first_current", bus.current, 0);
        chk("t2_first_active", bus.tx_active, 1);
        chk("t2_first_addr", bus.sym_addr, 1);
        strobes = 1; active_cyc = 1; dones = 0; cyc = 0; last_cyc = 0;
        while (dones == 0 && cyc < 700) begin
            tick();
            cyc++;
            if (bus.tx_active) active_cyc++;
            if (bus.symbol_strobe) begin
                chk("t2_spacing", cyc - last_cyc, 4);
                chk("t2_current", bus.current, strobes % 4);
                chk("t2_addr", bus.sym_addr, (strobes + 1 > 161) ? 161 : strobes + 1);
                strobes++;
                last_cyc = cyc;
            end
            if (bus.done) begin
                dones++;
                chk("t2_done_active", bus.tx_active, 0);
                chk("t2_done_current", bus.current, 0);
                chk("t2_done_addr", bus.sym_addr, 0);
            end
        end
        chk("t2_strobe_count", strobes, 162);
        chk("t2_active_cycles", active_cyc, 648);
        chk("t2_done_count", dones, 1);
        seen = 0;
        repeat (12) begin
            tick();
            if (bus.tx_active || bus.symbol_strobe || bus.done) seen++;
        end
        chk("t2_held_start_no_retrigger", seen, 0);
        $display("step full_tx: strobes=%0d active=%0d", strobes, active_cyc);

        // Start edge while no message is ready is dropped
        start = 1'b0; encoding_valid = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        repeat (8) tick();
        encoding_valid = 1'b1;
        seen = 0;
        repeat (12) begin
            tick();
            if (bus.tx_active || bus.symbol_strobe) seen++;
        end
        chk("t3_dropped_start", seen, 0);
        $display("step invalid_start: done");

        // Abort during symbol 50, then restart from address 0
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        wait_strobe("t4_first", 10, waited);
        for (int k = 1; k <= 50; k++) wait_strobe("t4_run", 10, waited);
        chk("t4_sym50_current", bus.current, 2);
        abort = 1'b1;
        tick();
        chk("t4_abort_active", bus.tx_active, 0);
        chk("t4_abort_current", bus.current, 0);
        chk("t4_abort_addr", bus.sym_addr, 0);
        chk("t4_abort_done", bus.done, 0);
        abort = 1'b0;
        seen = 0;
        repeat (8) begin
            tick();
            if (bus.done || bus.tx_active) seen++;
        end
        chk("t4_no_done_after_abort", seen, 0);
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        wait_strobe("t4_restart", 10, waited);
        chk("t4_restart_latency", waited, 5);
        chk("t4_restart_current", bus.current, 0);
        chk("t4_restart_addr", bus.sym_addr, 1);
        $display("step abort: done");

        // Message invalidated at symbol 100
        for (int k = 1; k <= 100; k++) wait_strobe("t5_run", 10, waited);
        chk("t5_sym100_addr", bus.sym_addr, 101);
        encoding_valid = 1'b0;
        tick();
        chk("t5_drop_active", bus.tx_active, 0);
        chk("t5_drop_current", bus.current, 0);
        chk("t5_drop_addr", bus.sym_addr, 0);
        chk("t5_drop_done", bus.done, 0);
        encoding_valid = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (bus.tx_active || bus.symbol_strobe || bus.done) seen++;
        end
        chk("t5_quiet_after_drop", seen, 0);

        // Abort on the same clock as a symbol boundary
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        wait_strobe("t5_first", 10, waited);
        repeat (3) tick();
        chk("t5_pre_boundary_strobe", bus.symbol_strobe, 0);
        abort = 1'b1;
        tick();
        chk("t5_boundary_strobe", bus.symbol_strobe, 0);
        chk("t5_boundary_active", bus.tx_active, 0);
        chk("t5_boundary_addr", bus.sym_addr, 0);
        abort = 1'b0;
        $display("step valid_drop_and_boundary_abort: done");

        // Slot synchronisation (or its absence)
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        first_cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            slot_tick = (c == 10);
            if (c == 8) begin
`ifdef WSPR_SLOT_SYNC_EN
                chk("t6_arm_inactive", bus.tx_active, 0);
`else
                chk("t6_running", bus.tx_active, 1);
`endif
            end
            if (bus.symbol_strobe && first_cyc == 0) first_cyc = c;
        end
`ifdef WSPR_SLOT_SYNC_EN
        chk("t6_first_strobe_cycle", first_cyc, 12);
`else
        chk("t6_first_strobe_cycle", first_cyc, 5);
`endif
        $display("step slot_sync: first strobe at clock %0d", first_cyc);

        // Asynchronous reset in the middle of a symbol
        repeat (2) tick();
        chk("t1_pre_reset_active", bus.tx_active, 1);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("t1_async_current", bus.current, 0);
        chk("t1_async_addr", bus.sym_addr, 0);
        chk("t1_async_active", bus.tx_active, 0);
        chk("t1_async_strobe", bus.symbol_strobe, 0);
        chk("t1_async_done", bus.done, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (bus.tx_active || bus.symbol_strobe || bus.done) seen++;
        end
        chk("t1_idle_after_reset", seen, 0);
        $display("step async_reset: done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
